// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared types and constants for the uart_byte_tx transmitter.
//   - state_t    : transmitter FSM states (2-bit encoding)
//   - DATA_BITS  : payload bits per UART frame
//   - FRAME_BITS : start + data + stop bits per frame (8N1)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_byte_tx_if.sv
// -----------------------------------------------------------------------------
// uart_byte_tx_if
//   Byte-stream in / UART line out bundle for uart_byte_tx.
//   Ports (seen from the slave, i.e. the transmitter):
//     data       in  8                 byte to send, sampled on the send rising edge
//     send       in  1                 request strobe, rising edge = one byte
//     tx         out 1                 UART serial line, idle high
//     busy       out 1                 frame in progress or bytes queued
//     overflow   out 1                 sticky, a byte was dropped on a full FIFO
//     fifo_count out clog2(DEPTH)+1    current FIFO occupancy
//   master = byte source, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_byte_tx_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]       data;
    logic             send;
    logic             tx;
    logic             busy;
    logic             overflow;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output data, send,
        input  tx, busy, overflow, fifo_count
    );

    modport slave (
        input  data, send,
        output tx, busy, overflow, fifo_count
    );

endinterface

// File: rtl/uart_byte_tx_fifo.sv
// -----------------------------------------------------------------------------
// byte_fifo
//   Small synchronous byte FIFO. The head entry is presented combinationally
//   from a registered read pointer, so a pop consumes the byte visible in the
//   same cycle. A write while full is only honoured together with a read.
//   Ports:
//     clk, rst  clock / asynchronous active-high reset
//     wr_en     write request, wr_data  byte to write
//     rd_en     pop request,   rd_data  current head entry
//     count     occupancy 0..DEPTH, full / empty status
// -----------------------------------------------------------------------------
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic                   rd_en,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int                 PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]     FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [DATA_BITS-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [PTR_W:0]       r_count;
    logic                 w_do_wr;
    logic                 w_do_rd;

    assign empty   = (r_count == '0);
    assign full    = (r_count == FULL_CNT);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    // NOTE: storage has no reset; only the pointers and count define validity,
    // so clearing the array would just cost reset routing for nothing.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Pointers are log2(DEPTH) wide and wrap naturally.
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
//   Captures one byte per rising edge of send into a byte FIFO and serializes
//   queued bytes as 8N1 UART frames, LSB first, with no idle gap between
//   back-to-back frames.
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous active-high reset
//     bus   uart_byte_tx_if slave: data/send in; tx/busy/overflow/fifo_count out
//   Parameters:
//     CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//     FIFO_DEPTH    byte buffer entries (power of 2, >= 2)
// -----------------------------------------------------------------------------
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_byte_tx_if.slave bus
);

    localparam int                  CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int                  BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]   BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]          BIT_LAST  = 3'(DATA_BITS - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [BAUD_W-1:0]    r_baud;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 r_send_q;
    logic                 r_armed;
    logic                 r_overflow;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_baud_done;
    logic                 w_last_bit;
    logic [DATA_BITS-1:0] w_head;
    logic [CNT_W-1:0]     w_count;
    logic                 w_full;
    logic                 w_empty;

    // -------------------------------------------------------------------------
    // send edge detect. r_armed blocks a level of send that was already high
    // when reset released: a push needs send to be seen low first.
    // -------------------------------------------------------------------------
    assign w_push   = bus.send & ~r_send_q & r_armed;
    // A full FIFO still takes the byte when the transmitter pops this cycle.
    assign w_accept = w_push & (~w_full | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_send_q   <= 1'b0;
            r_armed    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_send_q <= bus.send;
            if (!bus.send) begin
                r_armed <= 1'b1;
            end
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_accept),
        .wr_data (bus.data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    // -------------------------------------------------------------------------
    // Transmit FSM
    // -------------------------------------------------------------------------
    assign w_baud_done = (r_baud == BAUD_LAST);
    assign w_last_bit  = (r_bit_idx == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a signal unassigned and infers a latch.
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_next    = 1'b1;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                w_tx_next = 1'b0;
                if (w_baud_done) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                w_tx_next = r_shift[0];
                if (w_baud_done && w_last_bit) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    // Chain straight into the next start bit when more is queued.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Baud/bit counters, shift register and the registered line driver.
    // tx follows the state one cycle later, so it never sees input glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            // Restart the bit timer on every state entry and on each wrap.
            if (r_state == IDLE || w_state_next != r_state || w_baud_done) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end

            if (r_state != DATA) begin
                r_bit_idx <= '0;
            end else if (w_baud_done) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end

            if (w_pop) begin
                r_shift <= w_head;
            end else if (r_state == DATA && w_baud_done) begin
                r_shift <= r_shift >> 1;
            end

            r_tx <= w_tx_next;
        end
    end

    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != IDLE) | (w_count != '0);
    assign bus.overflow   = r_overflow;
    assign bus.fifo_count = w_count;

endmodule

// File: tb/tb_uart_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_tx
//   Self-checking bench for uart_byte_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
//   The reference model keeps the queued bytes in a queue and derives the
//   expected line level from the pop cycle of the current frame with plain
//   arithmetic (frame bit = elapsed cycles / CLKS_PER_BIT).
// -----------------------------------------------------------------------------
module tb_uart_byte_tx;
    import uart_pkg::FRAME_BITS;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int FRAME = FRAME_BITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_byte_tx_if #(.FIFO_DEPTH(DEPTH)) u_if ();

    uart_byte_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [7:0] m_q[$];
    logic       m_prev;
    logic       m_armed;
    logic       m_have;
    logic       m_ovf;
    logic       m_tx;
    logic       m_busy;
    int         m_pop_cyc;
    logic [7:0] m_byte;

    task automatic model_reset();
        m_q.delete();
        m_prev    = 1'b0;
        m_armed   = 1'b0;
        m_have    = 1'b0;
        m_ovf     = 1'b0;
        m_tx      = 1'b1;
        m_busy    = 1'b0;
        m_pop_cyc = 0;
        m_byte    = '0;
    endtask

    // Drive one clock of stimulus and advance the model; returns #1 after the edge.
    task automatic step(input logic s, input logic [7:0] d);
        logic push;
        logic pop;
        logic full_before;
        int   bit_no;
        @(negedge clk);
        u_if.send = s;
        u_if.data = d;
        @(posedge clk);
        cyc++;
        push        = s & ~m_prev & m_armed;
        m_armed     = m_armed | ~s;
        m_prev      = s;
        full_before = (m_q.size() == DEPTH);
        pop         = (m_q.size() != 0) && (!m_have || cyc >= m_pop_cyc + FRAME);
        if (pop) begin
            m_byte    = m_q.pop_front();
            m_pop_cyc = cyc;
            m_have    = 1'b1;
        end
        if (push) begin
            if (!full_before || pop) m_q.push_back(d);
            else                     m_ovf = 1'b1;
        end
        m_busy = (m_q.size() != 0) || (m_have && cyc < m_pop_cyc + FRAME);
        m_tx   = 1'b1;
        if (m_have && cyc > m_pop_cyc && cyc <= m_pop_cyc + FRAME) begin
            bit_no = (cyc - m_pop_cyc - 1) / CPB;
            if (bit_no == 0)     m_tx = 1'b0;
            else if (bit_no < 9) m_tx = m_byte[bit_no-1];
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        u_if.send = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 8'h00);
    endtask

    task automatic test_reset();
        u_if.send = 1'b0;
        u_if.data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (u_if.tx !== 1'b1) begin
            errors++; $display("FAIL reset_tx got=%b want=1", u_if.tx);
        end
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got=%b want=0", u_if.busy);
        end
        checks++;
        if (u_if.overflow !== 1'b0) begin
            errors++; $display("FAIL reset_overflow got=%b want=0", u_if.overflow);
        end
        checks++;
        if (u_if.fifo_count !== '0) begin
            errors++; $display("FAIL reset_count got=%0d want=0", u_if.fifo_count);
        end
        rst = 1'b0;
        step(1'b0, 8'h00);
    endtask

    task automatic test_single();
        logic [9:0] pat = 10'b1101001010;
        int         busy_cycles = 0;
        for (int i = 0; i < FRAME + 8; i++) begin
            if (i == 0) step(1'b1, 8'hA5);
            else        step(1'b0, 8'h00);
            if (u_if.busy === 1'b1) busy_cycles++;
            checks++;
            if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.overflow !== m_ovf ||
                u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL single cyc=%0d got tx=%b busy=%b ovf=%b cnt=%0d want tx=%b busy=%b ovf=%b cnt=%0d",
                         cyc, u_if.tx, u_if.busy, u_if.overflow, u_if.fifo_count,
                         m_tx, m_busy, m_ovf, m_q.size());
            end
            if (i == 1) begin
                checks++;
                if (u_if.tx !== 1'b1) begin
                    errors++; $display("FAIL single_early_start got=%b want=1", u_if.tx);
                end
            end
            if (i >= 2 && i < 2 + FRAME) begin
                checks++;
                if (u_if.tx !== pat[(i-2)/CPB]) begin
                    errors++;
                    $display("FAIL single_cell i=%0d got=%b want=%b", i, u_if.tx, pat[(i-2)/CPB]);
                end
            end
        end
        checks++;
        if (busy_cycles != FRAME + 1) begin
            errors++; $display("FAIL single_busy_len got=%0d want=%0d", busy_cycles, FRAME + 1);
        end
    endtask

    task automatic test_hold();
        int peak = 0;
        for (int i = 0; i < 7 + FRAME + 10; i++) begin
            step((i < 7) ? 1'b1 : 1'b0, 8'h3C);
            if (int'(u_if.fifo_count) > peak) peak = int'(u_if.fifo_count);
            checks++;
            if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.overflow !== m_ovf ||
                u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL hold cyc=%0d got tx=%b busy=%b cnt=%0d want tx=%b busy=%b cnt=%0d",
                         cyc, u_if.tx, u_if.busy, u_if.fifo_count, m_tx, m_busy, m_q.size());
            end
        end
        checks++;
        if (peak != 1) begin
            errors++; $display("FAIL hold_peak got=%0d want=1", peak);
        end
    endtask

    task automatic test_burst();
        for (int i = 0; i < 6 * 2 + 5 * FRAME + 10; i++) begin
            if (i < 12) step(~i[0], 8'(i / 2 + 1));
            else        step(1'b0, 8'h00);
            checks++;
            if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.overflow !== m_ovf ||
                u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL burst cyc=%0d got tx=%b busy=%b ovf=%b cnt=%0d want tx=%b busy=%b ovf=%b cnt=%0d",
                         cyc, u_if.tx, u_if.busy, u_if.overflow, u_if.fifo_count,
                         m_tx, m_busy, m_ovf, m_q.size());
            end
            if (i == 10) begin
                checks++;
                if (u_if.overflow !== 1'b1 || u_if.fifo_count !== CNT_W'(DEPTH)) begin
                    errors++;
                    $display("FAIL burst_drop got ovf=%b cnt=%0d want ovf=1 cnt=%0d",
                             u_if.overflow, u_if.fifo_count, DEPTH);
                end
            end
        end
    endtask

    task automatic test_collision();
        int guard = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(~i[0], 8'h10 + 8'(i / 2));
        end
        while (cyc < m_pop_cyc + FRAME - 1 && guard < 2 * FRAME) begin
            guard++;
            step(1'b0, 8'h00);
            checks++;
            if (u_if.tx !== m_tx || u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL collision_wait cyc=%0d got tx=%b cnt=%0d want tx=%b cnt=%0d",
                         cyc, u_if.tx, u_if.fifo_count, m_tx, m_q.size());
            end
        end
        step(1'b1, 8'h77);
        checks++;
        if (u_if.overflow !== 1'b0 || u_if.fifo_count !== CNT_W'(DEPTH)) begin
            errors++;
            $display("FAIL collision_accept got ovf=%b cnt=%0d want ovf=0 cnt=%0d",
                     u_if.overflow, u_if.fifo_count, DEPTH);
        end
        for (int i = 0; i < 5 * FRAME + 10; i++) begin
            step(1'b0, 8'h00);
            checks++;
            if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.overflow !== m_ovf ||
                u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL collision cyc=%0d got tx=%b busy=%b ovf=%b cnt=%0d want tx=%b busy=%b ovf=%b cnt=%0d",
                         cyc, u_if.tx, u_if.busy, u_if.overflow, u_if.fifo_count,
                         m_tx, m_busy, m_ovf, m_q.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(1'b1, 8'hFF);
        step(1'b0, 8'h00);
        step(1'b1, 8'hAA);
        step(1'b0, 8'h00);
        step(1'b1, 8'hBB);
        step(1'b0, 8'h00);
        while (cyc < m_pop_cyc + 3 * CPB) step(1'b0, 8'h00);
        checks++;
        if (u_if.fifo_count !== CNT_W'(2) || u_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre got cnt=%0d busy=%b want cnt=2 busy=1", u_if.fifo_count, u_if.busy);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (u_if.tx !== 1'b1 || u_if.fifo_count !== '0 || u_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async got tx=%b cnt=%0d busy=%b want tx=1 cnt=0 busy=0",
                     u_if.tx, u_if.fifo_count, u_if.busy);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3 * FRAME + FRAME + 12; i++) begin
            if (i == 3 * FRAME) step(1'b1, 8'h55);
            else                step(1'b0, 8'h00);
            checks++;
            if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.overflow !== m_ovf ||
                u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL midreset cyc=%0d got tx=%b busy=%b cnt=%0d want tx=%b busy=%b cnt=%0d",
                         cyc, u_if.tx, u_if.busy, u_if.fifo_count, m_tx, m_busy, m_q.size());
            end
        end
    endtask

    task automatic test_send_through_reset();
        @(negedge clk);
        u_if.send = 1'b1;
        u_if.data = 8'h11;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 7 + FRAME + 10; i++) begin
            if (i < 4)       step(1'b1, 8'h11);
            else if (i == 6) step(1'b1, 8'h80);
            else             step(1'b0, 8'h00);
            checks++;
            if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.overflow !== m_ovf ||
                u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL held_send cyc=%0d got tx=%b busy=%b cnt=%0d want tx=%b busy=%b cnt=%0d",
                         cyc, u_if.tx, u_if.busy, u_if.fifo_count, m_tx, m_busy, m_q.size());
            end
            if (i == 3 || i == 6) begin
                checks++;
                if (u_if.fifo_count !== CNT_W'((i == 6) ? 1 : 0)) begin
                    errors++;
                    $display("FAIL held_send_count i=%0d got=%0d want=%0d",
                             i, u_if.fifo_count, (i == 6) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold;
        int gap;
        int guard = 0;
        logic [7:0] d;
        do_reset();
        for (int n = 0; n < 24; n++) begin
            d    = 8'($urandom);
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, FRAME / 2);
            for (int i = 0; i < hold + gap; i++) begin
                step((i < hold) ? 1'b1 : 1'b0, d);
                checks++;
                if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.overflow !== m_ovf ||
                    u_if.fifo_count !== CNT_W'(m_q.size())) begin
                    errors++;
                    $display("FAIL random cyc=%0d got tx=%b busy=%b ovf=%b cnt=%0d want tx=%b busy=%b ovf=%b cnt=%0d",
                             cyc, u_if.tx, u_if.busy, u_if.overflow, u_if.fifo_count,
                             m_tx, m_busy, m_ovf, m_q.size());
                end
            end
        end
        while ((m_busy || u_if.busy) && guard < (DEPTH + 2) * FRAME) begin
            guard++;
            step(1'b0, 8'h00);
            checks++;
            if (u_if.tx !== m_tx || u_if.busy !== m_busy || u_if.fifo_count !== CNT_W'(m_q.size())) begin
                errors++;
                $display("FAIL random_drain cyc=%0d got tx=%b busy=%b cnt=%0d want tx=%b busy=%b cnt=%0d",
                         cyc, u_if.tx, u_if.busy, u_if.fifo_count, m_tx, m_busy, m_q.size());
            end
        end
        checks++;
        if (u_if.busy !== 1'b0) begin
            errors++; $display("FAIL random_idle got busy=%b want=0 after %0d cycles", u_if.busy, guard);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.send = 1'b0;
        u_if.data = '0;
        model_reset();
        test_reset();
        test_single();
        test_hold();
        test_burst();
        test_collision();
        test_reset_mid();
        test_send_through_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Synthesizable consumer for the byte-stream interface `data[7:0]` plus `send` strobe. It captures each byte announced by a rising edge on `send` into a small FIFO. It then serializes the bytes onto a UART line, 8N1 format, LSB first. It sits between the byte source (file reader in simulation, logic in hardware) and the board TX pin, and absorbs bursts that arrive faster than one frame time.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; legal range ≥ 2.
- FIFO_DEPTH, 4, byte buffer entries; must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- data  in  8  byte to send; sampled on the clk edge that detects the `send` rising edge.
- send  in  1  strobe; synchronous to clk; a rising edge requests one byte; high duration is irrelevant.
- tx  out  1  UART serial line; idle high.
- busy  out  1  high while a frame is in progress or the FIFO is non-empty.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset is asynchronous and active-high. While asserted:
  - tx=1, busy=0, overflow=0, fifo_count=0.
  - FSM in IDLE; bit and baud counters at 0.
  - The `send` history register is cleared to 0.
- Edge detect: register `send_q` each cycle. push = send & ~send_q.
  - `send` held high for N cycles produces exactly one push.
  - `send` high during reset release does not cause a push until it goes low then high again.
- FIFO accept rule: on push, write `data` if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
- Overflow: otherwise the byte is dropped, overflow←1, and it stays 1 until reset.
- Simultaneous push and pop: count is unchanged; the pop returns the oldest entry, never the one being written.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO is non-empty, pop into shift register and go to START. If empty, stay; tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles, then shift right and increment bit_idx. After bit_idx=7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- tx is a registered output, glitch-free, with no combinational path from inputs.
- Latency:
  - Push edge at cycle N (FIFO empty, IDLE) → pop at N+1 → tx falls at N+2.
  - Frame length is exactly 10×CLKS_PER_BIT cycles.
- Baud counter runs 0..CLKS_PER_BIT-1 and wraps; it is reset to 0 on every state entry.
- Width rules: bit_idx is 3 bits; fifo_count saturates logically at FIFO_DEPTH and never wraps.
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Reset mid-frame: tx returns to 1 immediately (asynchronous), the frame is truncated, and FIFO contents are discarded.
- busy = (state≠IDLE) | (fifo_count≠0). busy is low in the first cycle after the last STOP bit ends.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE/START/DATA/STOP, 2-bit encoding).
  - DATA_BITS=8 and FRAME_BITS=10 constants.
- Sub-module byte_fifo(DEPTH):
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Synchronous read of the head entry via a registered pointer, combinational head output.
- The top level contains the edge detect, overflow flag, FSM and baud/bit counters.

Test Plan:
1. CLKS_PER_BIT=4, single push of 0xA5 → tx falls 2 cycles after the push edge; bit cells read 0,1,0,1,0,0,1,0,1,1 for 4 cycles each; busy=1 for 40+1 cycles; overflow=0.
2. `send` held high 7 cycles with data=0x3C → exactly one frame (0,0,0,1,1,1,1,0,0,1); fifo_count peaks at 1.
3. Six pushes 0x01..0x06, 2 cycles apart, during the first frame:
   - 0x01 is popped immediately; 0x02..0x05 fill the FIFO; 0x06 is dropped and overflow=1.
   - Five frames go out back-to-back with no idle-high gap between STOP and START.
4. FIFO full and STOP ending in the same cycle as a push of 0x77 → push accepted, overflow stays 0, 0x77 is sent last.
5. Assert rst for 1 cycle mid-DATA of 0xFF with 2 bytes queued → tx=1 at once, fifo_count=0, busy=0; no further frames; a new push of 0x55 afterwards transmits correctly.
6. `send` high during reset release, then low, then high with 0x80 → exactly one frame (0x80); no frame for the level held through reset.
